// File: rtl/ldpc_uart_tx_scheduler.sv
// Round-robin byte scheduler feeding an external (8,16) LDPC encoder and
// serialising each codeword as one UART frame: start, 16 bits LSB first, stop.
module ldpc_uart_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int SRC_W        = 2,
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           enc_msg,
  input  logic [15:0]          enc_codeword,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done,
  output logic [SRC_W-1:0]     frame_src
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

  state_t             state;
  logic [SRC_W-1:0]   ptr;
  logic [BAUD_W-1:0]  baud_cnt;
  logic [3:0]         bit_cnt;
  logic [15:0]        shift_reg;
  logic               bit_end;
  logic [SRC_W-1:0]   winner;
  logic [SRC_W-1:0]   cand;
  logic               found;
  logic [7:0]         src_byte [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_src
    assign src_byte[i] = req_data[8*i +: 8];
  end

  assign bit_end = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

  // First set request searching upward from the source after the last winner.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = SRC_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= SRC_W'(NUM_REQ - 1);
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      enc_msg    <= '0;
      grant      <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_src  <= '0;
    end else begin
      grant      <= '0;
      frame_done <= 1'b0;
      if (state == START || state == DATA || state == STOP) begin
        baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (found) begin
            enc_msg   <= src_byte[winner];
            grant     <= NUM_REQ'(1) << winner;
            frame_src <= winner;
            ptr       <= winner;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          shift_reg <= enc_codeword;
          baud_cnt  <= '0;
          tx        <= 1'b0;
          state     <= START;
        end
        START: begin
          if (bit_end) begin
            tx      <= shift_reg[0];
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == 4'd15) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx        <= shift_reg[1];
              shift_reg <= shift_reg >> 1;
              bit_cnt   <= bit_cnt + 4'd1;
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
